nco_clkgen: RTL and testbench

Synthesizable numerically controlled clock generator: a phase accumulator clocked by `clkin` that synthesizes `clkout` at a programmable fraction of the input frequency. Frequency changes either jump or ramp linearly toward a target. It is the source end of the frequency-measurement path: it drives the same `clkout` net that the frequency monitor and the PLL loop benches read. It also serves as a deterministic stimulus clock for loop-filter characterization.

---
 rtl/nco_clkgen.sv | 144 ++++++++++++++
 tb/tb_nco_clkgen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nco_clkgen.sv
// nco_clkgen -- numerically controlled clock generator.
//
// A phase accumulator advances by fcw_cur on every enabled clkin edge, and
// clkout is its registered MSB, so f_out = fcw_cur / 2^ACC_W * f_clkin.
// A new target FCW is accepted through a valid/ready handshake. It is either
// applied at once (step 0, or the target already equals fcw_cur) or approached
// linearly by step_in per cycle. The ramp saturates at the target, so it never
// overshoots and never wraps. The accumulator runs independently of the ramp
// FSM, which keeps frequency changes phase-continuous.
//
// Ports:
//   clkin        sole clock, rising edge
//   rst_n        synchronous active-low reset
//   cfg_valid    new target FCW / step offered
//   cfg_ready    configuration can be accepted (IDLE or HOLD)
//   fcw_in       target frequency control word
//   step_in      ramp increment per cycle, 0 = jump
//   en           accumulator advance enable
//   clkout       synthesized clock (registered accumulator MSB)
//   clkout_rise  one-cycle pulse on the cycle clkout goes 0->1
//   fcw_cur      frequency control word currently applied
//   busy         ramp in progress
//   settled      fcw_cur equals the last accepted target
module nco_clkgen #(
  parameter int ACC_W  = 32,
  parameter int STEP_W = 16
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  fcw_in,
  input  logic [STEP_W-1:0] step_in,
  input  logic              en,
  output logic              clkout,
  output logic              clkout_rise,
  output logic [ACC_W-1:0]  fcw_cur,
  output logic              busy,
  output logic              settled
);

  localparam int EXT_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   tgt, tgt_nxt;
  logic [STEP_W-1:0]  stp, stp_nxt;
  logic [ACC_W-1:0]   fcw_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic               accept;

  // One ramp step from cur toward target, saturated at target. The extra bit
  // catches both the carry above 2^ACC_W and the borrow below zero, so the
  // result can neither wrap nor pass the target.
  function automatic logic [ACC_W-1:0] ramp_step(
    input logic [ACC_W-1:0]  cur,
    input logic [ACC_W-1:0]  target,
    input logic [STEP_W-1:0] step
  );
    logic [EXT_W-1:0] ext_step;
    logic [EXT_W-1:0] ext_cur;
    logic [EXT_W-1:0] ext_tgt;
    logic [EXT_W-1:0] moved;
    ext_step = EXT_W'(step);
    ext_cur  = {1'b0, cur};
    ext_tgt  = {1'b0, target};
    if (target > cur) begin
      moved = ext_cur + ext_step;
      ramp_step = (moved > ext_tgt) ? target : moved[ACC_W-1:0];
    end else begin
      moved = ext_cur - ext_step;
      // moved[ACC_W] set means the subtraction borrowed below zero
      ramp_step = (moved[ACC_W] || (moved < ext_tgt)) ? target : moved[ACC_W-1:0];
    end
  endfunction

  assign cfg_ready = (state != RAMP);
  assign busy      = (state == RAMP);
  assign settled   = (state == HOLD);
  assign accept    = cfg_valid && cfg_ready;

  // The first ramp step is taken on the accept edge itself, so a jump and a
  // single-step ramp both land one cycle after the handshake.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    stp_nxt   = stp;
    fcw_nxt   = fcw_cur;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          tgt_nxt = fcw_in;
          stp_nxt = step_in;
          if ((step_in == '0) || (fcw_in == fcw_cur)) begin
            fcw_nxt   = fcw_in;
            state_nxt = HOLD;
          end else begin
            fcw_nxt   = ramp_step(fcw_cur, fcw_in, step_in);
            state_nxt = (fcw_nxt == fcw_in) ? HOLD : RAMP;
          end
        end
      end
      RAMP: begin
        fcw_nxt = ramp_step(fcw_cur, tgt, stp);
        if (fcw_nxt == tgt) begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Adds the registered fcw_cur: an FCW change affects the next increment.
  assign acc_nxt = en ? (acc + fcw_cur) : acc;

  // ---- control / phase registers ----
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state       <= IDLE;
      fcw_cur     <= '0;
      acc         <= '0;
      clkout      <= 1'b0;
      clkout_rise <= 1'b0;
    end else begin
      state       <= state_nxt;
      fcw_cur     <= fcw_nxt;
      acc         <= acc_nxt;
      clkout      <= acc_nxt[ACC_W-1];
      clkout_rise <= en && !clkout && acc_nxt[ACC_W-1];
    end
  end

  // ---- latched target / step (only read while ramping) ----
  always_ff @(posedge clkin) begin
    tgt <= tgt_nxt;
    stp <= stp_nxt;
  end

endmodule

// File: tb/tb_nco_clkgen.sv
// Testbench for nco_clkgen: directed steps from the test plan followed by a
// randomized run, every cycle compared against a behavioural model that
// tracks frequency, target and phase with plain integer arithmetic.
module tb_nco_clkgen;

  localparam int ACC_W  = 32;
  localparam int STEP_W = 16;
  localparam longint MOD = 64'h1_0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ACC_W-1:0]  fcw_in = '0;
  logic [STEP_W-1:0] step_in = '0;
  logic              en = 1'b0;
  logic              clkout;
  logic              clkout_rise;
  logic [ACC_W-1:0]  fcw_cur;
  logic              busy;
  logic              settled;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  longint m_fcw  = 0;
  longint m_tgt  = 0;
  longint m_stp  = 0;
  longint m_acc  = 0;
  bit     m_clk  = 0;
  bit     m_rise = 0;
  bit     m_ramping = 0;
  bit     m_have_tgt = 0;

  nco_clkgen #(.ACC_W(ACC_W), .STEP_W(STEP_W)) dut (
    .clkin       (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .fcw_in      (fcw_in),
    .step_in     (step_in),
    .en          (en),
    .clkout      (clkout),
    .clkout_rise (clkout_rise),
    .fcw_cur     (fcw_cur),
    .busy        (busy),
    .settled     (settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move cur toward tgt by stp without passing it.
  function automatic longint approach(input longint cur, input longint tgt, input longint stp);
    longint v;
    if (tgt > cur) begin
      v = cur + stp;
      return (v > tgt) ? tgt : v;
    end
    v = cur - stp;
    return (v < tgt) ? tgt : v;
  endfunction

  // Advance the model by one clkin edge using the inputs currently driven.
  task automatic model_edge();
    longint phase;
    if (!rst_n) begin
      m_fcw = 0; m_acc = 0; m_clk = 0; m_rise = 0;
      m_ramping = 0; m_have_tgt = 0;
      return;
    end
    if (en) begin
      phase  = (m_acc + m_fcw) % MOD;
      m_rise = !m_clk && (phase >= MOD / 2);
      m_clk  = (phase >= MOD / 2);
      m_acc  = phase;
    end else begin
      m_rise = 0;
    end
    if (!m_ramping && cfg_valid) begin
      m_tgt = longint'(fcw_in);
      m_stp = longint'(step_in);
      m_have_tgt = 1;
      if (m_stp == 0) m_fcw = m_tgt;
      else            m_fcw = approach(m_fcw, m_tgt, m_stp);
      m_ramping = (m_fcw != m_tgt);
    end else if (m_ramping) begin
      m_fcw = approach(m_fcw, m_tgt, m_stp);
      m_ramping = (m_fcw != m_tgt);
    end
  endtask

  // One clock: update model, take the edge, compare all outputs 1ns later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("fcw_cur", longint'(fcw_cur), m_fcw);
    chk("clkout", longint'(clkout), longint'(m_clk));
    chk("clkout_rise", longint'(clkout_rise), longint'(m_rise));
    chk("cfg_ready", longint'(cfg_ready), longint'(!m_ramping));
    chk("busy", longint'(busy), longint'(m_ramping));
    chk("settled", longint'(settled), longint'(m_have_tgt && !m_ramping));
  endtask

  initial begin
    int rises;
    int lim;
    bit frozen;
    bit reached;
    longint exp_seq[4];

    // reset
    rst_n = 0; en = 1;
    tick(); tick();
    chk("rst_fcw", longint'(fcw_cur), 0);
    chk("rst_ready", longint'(cfg_ready), 1);
    chk("rst_settled", longint'(settled), 0);
    chk("rst_clkout", longint'(clkout), 0);

    // jump to quarter rate
    rst_n = 1; cfg_valid = 1; fcw_in = 32'h4000_0000; step_in = 0;
    tick();
    cfg_valid = 0;
    chk("jump_settled", longint'(settled), 1);
    chk("jump_fcw", longint'(fcw_cur), 64'h4000_0000);
    rises = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("q_clkout", longint'(clkout), longint'((k % 4 == 2) || (k % 4 == 3)));
      if (clkout_rise) rises++;
    end
    chk("q_rises", rises, 3);

    // freeze with en low, then resume
    frozen = clkout;
    en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("frz_clkout", longint'(clkout), longint'(frozen));
      chk("frz_rise", longint'(clkout_rise), 0);
    end
    en = 1;
    rises = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (clkout_rise) rises++;
    end
    chk("freq_1000", longint'((rises >= 249) && (rises <= 251)), 1);

    // ramp up from 0
    rst_n = 0; tick(); rst_n = 1;
    cfg_valid = 1; fcw_in = 32'h1000; step_in = 16'h400;
    exp_seq = '{64'h400, 64'h800, 64'hC00, 64'h1000};
    for (int k = 0; k < 4; k++) begin
      tick();
      cfg_valid = 0;
      chk("up_fcw", longint'(fcw_cur), exp_seq[k]);
      chk("up_busy", longint'(busy), longint'(k < 3));
      chk("up_settled", longint'(settled), longint'(k == 3));
    end

    // ramp down with saturation
    cfg_valid = 1; fcw_in = 32'h0A00; step_in = 16'h400;
    tick();
    cfg_valid = 0;
    chk("dn_fcw0", longint'(fcw_cur), 64'hC00);
    chk("dn_busy", longint'(busy), 1);
    tick();
    chk("dn_fcw1", longint'(fcw_cur), 64'hA00);
    chk("dn_settled", longint'(settled), 1);

    // request held during a ramp
    cfg_valid = 1; fcw_in = 32'h2000; step_in = 16'h100;
    tick();
    fcw_in = 32'h3000; step_in = 0;
    reached = 0;
    lim = 0;
    while (!reached && lim < 40) begin
      tick();
      lim++;
      if (fcw_cur == 32'h2000) reached = 1;
      else chk("held_ready", longint'(cfg_ready), 0);
    end
    chk("held_reach_orig", longint'(reached), 1);
    chk("held_ready_hold", longint'(cfg_ready), 1);
    tick();
    cfg_valid = 0;
    chk("held_accepted", longint'(fcw_cur), 64'h3000);

    // reset mid-ramp with a pending request
    cfg_valid = 1; fcw_in = 32'h10_0000; step_in = 16'h10;
    tick();
    fcw_in = 32'h5555; step_in = 0;
    tick(); tick();
    chk("mid_busy", longint'(busy), 1);
    rst_n = 0;
    tick();
    chk("mrst_fcw", longint'(fcw_cur), 0);
    chk("mrst_clkout", longint'(clkout), 0);
    chk("mrst_ready", longint'(cfg_ready), 1);
    chk("mrst_busy", longint'(busy), 0);
    chk("mrst_settled", longint'(settled), 0);
    rst_n = 1; cfg_valid = 0;
    tick();
    chk("post_rst_fcw", longint'(fcw_cur), 0);

    // randomized run against the model
    for (int k = 0; k < 600; k++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      en        = ($urandom_range(0, 7) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      fcw_in    = $urandom & 32'h0003_FFFF;
      if ($urandom_range(0, 15) == 0) fcw_in = $urandom;
      step_in   = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(16'h100, 16'hFFFF));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
